intra4x4_mb_pred_parser: RTL and testbench
==========================================

INTRA4X4_MB_PRED_PARSER -- requirements
Module: intra4x4_mb_pred_parser

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-003 SHALL have start, input, 1, one-cycle pulse requesting mb_pred parsing of an I_NxN (Intra4x4) macroblock.
REQ-004 SHALL have bs_valid, input, 1, high when BitStream_buffer_output holds valid bits at the current bit pointer.
REQ-005 SHALL have BitStream_buffer_output, input, 16, next 16 bitstream bits; bit 15 is the next unread bit.
REQ-006 SHALL have mb_pred_state, output, 3, current parser state; codes taken from the shared defines header.
REQ-007 SHALL have luma4x4BlkIdx, output, 4, index of the 4x4 block being parsed.
REQ-008 SHALL have prev_intra4x4_pred_mode_flag, output, 1, decoded flag; valid in prev_intra4x4_pred_mode_flag_s.
REQ-009 SHALL have rem_intra4x4_pred_mode, output, 3, decoded remainder; valid in rem_intra4x4_pred_mode_s.
REQ-010 SHALL have intra_chroma_pred_mode, output, 2, decoded chroma mode; registered, held until next start.
REQ-011 SHALL have pc_advance, output, 3, bits consumed this cycle (0,1,3,5), to the bitstream controller.
REQ-012 SHALL have mb_pred_done, output, 1, one-cycle pulse at the end of successful parsing.
REQ-013 SHALL have mb_pred_err, output, 1, one-cycle pulse when the chroma codeword exceeds value 3.

Function
REQ-014 SHALL implement states IDLE (rst_s), PREV (prev_intra4x4_pred_mode_flag_s), REM (rem_intra4x4_pred_mode_s), CHROMA (intra_chroma_pred_mode_s); mb_pred_state registered.
REQ-015 IDLE: start=1 SHALL give PREV with luma4x4BlkIdx=0 next cycle; start outside IDLE SHALL be ignored.
REQ-016 Any non-IDLE state with bs_valid=0 SHALL hold state and luma4x4BlkIdx, drive pc_advance=0, and suppress done/err.
REQ-017 PREV, bs_valid=1: prev_intra4x4_pred_mode_flag = BitStream_buffer_output[15] (combinational); pc_advance=1.
REQ-018 PREV, flag=1: luma4x4BlkIdx<15 -> stay PREV, index+1; luma4x4BlkIdx=15 -> CHROMA, index held at 15.
REQ-019 PREV, flag=0 SHALL go to REM with luma4x4BlkIdx held.
REQ-020 REM, bs_valid=1: rem_intra4x4_pred_mode = BitStream_buffer_output[15:13]; pc_advance=3; next is CHROMA if index=15, else PREV with index+1.
REQ-021 Outside its valid state each of prev_intra4x4_pred_mode_flag and rem_intra4x4_pred_mode SHALL be 0.
REQ-022 CHROMA, bs_valid=1, ue(v) decode: [15]=1 -> 0, advance 1; [15:13]=010 -> 1, adv 3; 011 -> 2, adv 3; [15:11]=00100 -> 3, adv 5.
REQ-023 CHROMA, any other pattern SHALL give pc_advance=0, intra_chroma_pred_mode unchanged, mb_pred_err=1 next cycle, IDLE.
REQ-024 CHROMA success SHALL register intra_chroma_pred_mode, return to IDLE, pulse mb_pred_done next cycle (same cycle IDLE appears).
REQ-025 luma4x4BlkIdx SHALL return to 0 on entry to IDLE; 4-bit increment SHALL never wrap (guarded by REQ-018/020).
REQ-026 pc_advance SHALL be 0 in IDLE; total bits consumed per MB = 16 + 3*(count of flag=0) + chroma length.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force IDLE, luma4x4BlkIdx=0, intra_chroma_pred_mode=0, mb_pred_done=0, mb_pred_err=0, pc_advance=0, flag/rem outputs 0, regardless of current state.
REQ-028 Reset mid-parse SHALL discard partial MB; first start after release parses from luma4x4BlkIdx=0.

Verification
REQ-029 All 16 flags=1, chroma bit '1', bs_valid=1 -> 16 PREV cycles (pc_advance=1), CHROMA pc_advance=1, mode 0, done pulse; 18 cycles start->done.
REQ-030 Flags all 0, rem=5 each, chroma 00100 -> alternating PREV/REM (pc_advance 1,3), rem=5 in REM, chroma=3, pc_advance=5; total bits 69.
REQ-031 bs_valid low 2 cycles in REM at luma4x4BlkIdx=7 -> state/index held, pc_advance=0, then resumes with rem decode at index 7.
REQ-032 Chroma pattern 00110... -> mb_pred_err pulse, no done, intra_chroma_pred_mode retains previous value, IDLE.
REQ-033 reset_n=0 for one cycle at luma4x4BlkIdx=9 in REM -> IDLE, index 0, all outputs 0; next start re-parses from block 0.
REQ-034 start asserted during PREV -> ignored; sequence and done timing unchanged from REQ-029.

Source files
------------

// File: rtl/intra4x4_mb_pred_parser.sv
// Parses the mb_pred() syntax of an I_NxN macroblock: sixteen
// prev_intra4x4_pred_mode_flag / rem_intra4x4_pred_mode pairs followed by
// the ue(v) coded intra_chroma_pred_mode. It reports how many bits it
// consumed each cycle to the bitstream controller.
module intra4x4_mb_pred_parser (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        bs_valid,
  input  logic [15:0] BitStream_buffer_output,
  output logic [2:0]  mb_pred_state,
  output logic [3:0]  luma4x4BlkIdx,
  output logic        prev_intra4x4_pred_mode_flag,
  output logic [2:0]  rem_intra4x4_pred_mode,
  output logic [1:0]  intra_chroma_pred_mode,
  output logic [2:0]  pc_advance,
  output logic        mb_pred_done,
  output logic        mb_pred_err
);

  typedef enum logic [2:0] {
    rst_s                          = 3'd0,
    prev_intra4x4_pred_mode_flag_s = 3'd1,
    rem_intra4x4_pred_mode_s       = 3'd2,
    intra_chroma_pred_mode_s       = 3'd3
  } state_t;

  state_t     state;
  logic       chroma_ok;
  logic [1:0] chroma_val;
  logic [2:0] chroma_len;
  logic       unused_bits;

  // Only the top five bits ever carry syntax for this parser.
  assign unused_bits   = ^BitStream_buffer_output[10:0];
  assign mb_pred_state = state;

  // ue(v) decode of intra_chroma_pred_mode; codewords longer than 5 bits
  // (values above 3) are illegal and flagged via chroma_ok.
  always_comb begin
    chroma_ok  = 1'b1;
    chroma_val = 2'd0;
    chroma_len = 3'd0;
    casez (BitStream_buffer_output[15:11])
      5'b1????: begin chroma_val = 2'd0; chroma_len = 3'd1; end
      5'b010??: begin chroma_val = 2'd1; chroma_len = 3'd3; end
      5'b011??: begin chroma_val = 2'd2; chroma_len = 3'd3; end
      5'b00100: begin chroma_val = 2'd3; chroma_len = 3'd5; end
      default:  chroma_ok = 1'b0;
    endcase
  end

  // Decoded element outputs and bit consumption; all zero while stalled or idle.
  always_comb begin
    prev_intra4x4_pred_mode_flag = 1'b0;
    rem_intra4x4_pred_mode       = 3'd0;
    pc_advance                   = 3'd0;
    case (state)
      prev_intra4x4_pred_mode_flag_s: if (bs_valid) begin
        prev_intra4x4_pred_mode_flag = BitStream_buffer_output[15];
        pc_advance                   = 3'd1;
      end
      rem_intra4x4_pred_mode_s: if (bs_valid) begin
        rem_intra4x4_pred_mode = BitStream_buffer_output[15:13];
        pc_advance             = 3'd3;
      end
      intra_chroma_pred_mode_s: if (bs_valid && chroma_ok) begin
        pc_advance = chroma_len;
      end
      default: pc_advance = 3'd0;
    endcase
  end

  // Parser FSM with block index, chroma mode and done/error pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                  <= rst_s;
      luma4x4BlkIdx          <= 4'd0;
      intra_chroma_pred_mode <= 2'd0;
      mb_pred_done           <= 1'b0;
      mb_pred_err            <= 1'b0;
    end else begin
      mb_pred_done <= 1'b0;
      mb_pred_err  <= 1'b0;
      case (state)
        rst_s: begin
          luma4x4BlkIdx <= 4'd0;
          if (start) state <= prev_intra4x4_pred_mode_flag_s;
        end
        prev_intra4x4_pred_mode_flag_s: if (bs_valid) begin
          if (!BitStream_buffer_output[15]) begin
            state <= rem_intra4x4_pred_mode_s;
          end else if (luma4x4BlkIdx == 4'd15) begin
            state <= intra_chroma_pred_mode_s;
          end else begin
            luma4x4BlkIdx <= luma4x4BlkIdx + 4'd1;
          end
        end
        rem_intra4x4_pred_mode_s: if (bs_valid) begin
          if (luma4x4BlkIdx == 4'd15) begin
            state <= intra_chroma_pred_mode_s;
          end else begin
            state         <= prev_intra4x4_pred_mode_flag_s;
            luma4x4BlkIdx <= luma4x4BlkIdx + 4'd1;
          end
        end
        intra_chroma_pred_mode_s: if (bs_valid) begin
          if (chroma_ok) begin
            intra_chroma_pred_mode <= chroma_val;
            mb_pred_done           <= 1'b1;
          end else begin
            mb_pred_err <= 1'b1;
          end
          state         <= rst_s;
          luma4x4BlkIdx <= 4'd0;
        end
        default: begin
          state         <= rst_s;
          luma4x4BlkIdx <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intra4x4_mb_pred_parser.sv
// Scoreboard bench for intra4x4_mb_pred_parser: each macroblock is described
// as a list of syntax elements, serialised into a bit stream, and the
// expected consumption/termination events are queued for a separate monitor.
module tb_intra4x4_mb_pred_parser;

  localparam int S_IDLE = 0, S_PREV = 1, S_REM = 2, S_CHROMA = 3;

  logic        clk = 1'b0;
  logic        reset_n, start, bs_valid;
  logic [15:0] bs;
  logic [2:0]  mb_pred_state;
  logic [3:0]  luma4x4BlkIdx;
  logic        prev_flag;
  logic [2:0]  rem_mode;
  logic [1:0]  chroma_mode;
  logic [2:0]  pc_advance;
  logic        mb_pred_done, mb_pred_err;

  always #5 clk = ~clk;

  intra4x4_mb_pred_parser dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bs_valid(bs_valid),
    .BitStream_buffer_output(bs), .mb_pred_state(mb_pred_state),
    .luma4x4BlkIdx(luma4x4BlkIdx), .prev_intra4x4_pred_mode_flag(prev_flag),
    .rem_intra4x4_pred_mode(rem_mode), .intra_chroma_pred_mode(chroma_mode),
    .pc_advance(pc_advance), .mb_pred_done(mb_pred_done), .mb_pred_err(mb_pred_err)
  );

  // kind: 0 = bits consumed, 1 = done pulse, 2 = error pulse
  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] st;
    logic [3:0] idx;
    logic [2:0] adv;
    logic       flag;
    logic [2:0] rem;
    logic [1:0] mode;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors = 0, miscompares = 0;
  bit         stream[0:127];
  int         ptr;
  logic [1:0] model_mode;
  bit         mon_en = 0;
  bit         flags[16];
  logic [2:0] rems[16];

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic ev_t mk(input int kind, input int st, input int idx, input int adv,
                             input int flag, input int rem, input int mode);
    ev_t e;
    e.kind = kind[1:0]; e.st = st[2:0]; e.idx = idx[3:0]; e.adv = adv[2:0];
    e.flag = flag[0];   e.rem = rem[2:0]; e.mode = mode[1:0];
    return e;
  endfunction

  function automatic logic [15:0] window(input int p);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[15-k] = stream[p+k];
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(mb_pred_state), S_IDLE);
    chk({tag, "_idx"}, int'(luma4x4BlkIdx), 0);
    chk({tag, "_chroma"}, int'(chroma_mode), 0);
    chk({tag, "_done"}, int'(mb_pred_done), 0);
    chk({tag, "_err"}, int'(mb_pred_err), 0);
    chk({tag, "_adv"}, int'(pc_advance), 0);
    chk({tag, "_flag"}, int'(prev_flag), 0);
    chk({tag, "_rem"}, int'(rem_mode), 0);
  endtask

  // csel 0..3 = legal chroma value, 4..7 = illegal codeword
  task automatic run_mb(input int csel, input int valid_pct, input bit stall7,
                        input bit start_mid, input bit check_lat, input bit rst9);
    int n = 0, exp_bits, cyc = 0, lat = 0, stall_left = 0, clen;
    bit fin = 0, stalled = 0, aborted = 0;
    logic [4:0] cw;
    for (int k = 0; k < 128; k++) stream[k] = 1'($urandom_range(1));
    for (int i = 0; i < 16; i++) begin
      stream[n++] = flags[i];
      exp_q.push_back(mk(0, S_PREV, i, 1, int'(flags[i]), 0, 0));
      if (!flags[i]) begin
        for (int k = 0; k < 3; k++) stream[n++] = rems[i][2-k];
        exp_q.push_back(mk(0, S_REM, i, 3, 0, int'(rems[i]), 0));
      end
    end
    case (csel)
      0: begin cw = 5'b10000; clen = 1; end
      1: begin cw = 5'b01000; clen = 3; end
      2: begin cw = 5'b01100; clen = 3; end
      3: begin cw = 5'b00100; clen = 5; end
      4: begin cw = 5'b00110; clen = 5; end
      5: begin cw = 5'b00000; clen = 5; end
      6: begin cw = 5'b00101; clen = 5; end
      default: begin cw = 5'b00011; clen = 5; end
    endcase
    for (int k = 0; k < clen; k++) stream[n+k] = cw[4-k];
    if (csel < 4) begin
      exp_q.push_back(mk(0, S_CHROMA, 15, clen, 0, 0, 0));
      model_mode = csel[1:0];
      exp_q.push_back(mk(1, S_IDLE, 0, 0, 0, 0, int'(model_mode)));
      exp_bits = n + clen;
    end else begin
      exp_q.push_back(mk(2, S_IDLE, 0, 0, 0, 0, int'(model_mode)));
      exp_bits = n;
    end

    ptr = 0;
    @(negedge clk);
    start = 1'b1;
    bs_valid = 1'b0;
    bs = window(0);
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (start_mid && cyc == 5);
      if (mb_pred_done || mb_pred_err) begin
        fin = 1; lat = cyc;
      end else if (rst9 && mb_pred_state == S_REM && luma4x4BlkIdx == 4'd9) begin
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1 check_reset_outputs("midparse_reset");
        reset_n = 1'b1;
        model_mode = 2'd0;
        fin = 1; aborted = 1;
      end else begin
        if (stall7 && !stalled && mb_pred_state == S_REM && luma4x4BlkIdx == 4'd7) begin
          stall_left = 2; stalled = 1;
        end
        bs_valid = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < valid_pct);
        bs = window(ptr);
        #1;
        if (stall_left > 0) begin
          chk("stall_state", int'(mb_pred_state), S_REM);
          chk("stall_idx", int'(luma4x4BlkIdx), 7);
          chk("stall_adv", int'(pc_advance), 0);
          stall_left--;
        end
        ptr += int'(pc_advance);
      end
    end
    start = 1'b0;
    if (!fin) begin
      chk("mb_timeout", 0, 1);
      reset_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      model_mode = 2'd0;
    end else if (!aborted) begin
      chk("bits_consumed", ptr, exp_bits);
      if (check_lat) chk("start_to_done_cycles", lat, 18);
    end
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT consumes bits or ends an MB.
  initial begin
    forever begin
      ev_t e;
      int  act_kind;
      @(negedge clk);
      #2;
      if (mon_en && reset_n) begin
        if (pc_advance != 3'd0) begin
          if (exp_q.size() == 0) chk("unexpected_advance", int'(pc_advance), 0);
          else begin
            e = exp_q.pop_front();
            chk("adv_kind", 0, int'(e.kind));
            chk("adv_state", int'(mb_pred_state), int'(e.st));
            chk("adv_idx", int'(luma4x4BlkIdx), int'(e.idx));
            chk("adv_bits", int'(pc_advance), int'(e.adv));
            chk("adv_flag", int'(prev_flag), int'(e.flag));
            chk("adv_rem", int'(rem_mode), int'(e.rem));
          end
        end
        if (mb_pred_done || mb_pred_err) begin
          act_kind = mb_pred_done ? (mb_pred_err ? 3 : 1) : 2;
          if (exp_q.size() == 0) chk("unexpected_end", act_kind, 0);
          else begin
            e = exp_q.pop_front();
            chk("end_kind", act_kind, int'(e.kind));
            chk("end_chroma", int'(chroma_mode), int'(e.mode));
            chk("end_state", int'(mb_pred_state), S_IDLE);
            chk("end_idx", int'(luma4x4BlkIdx), 0);
          end
        end
        if (mb_pred_state != S_PREV && mb_pred_state != S_REM) begin
          chk("idle_flag_rem", int'({prev_flag, rem_mode}), 0);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; bs_valid = 1'b0; bs = 16'd0; model_mode = 2'd0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1;

    // All flags set, chroma 0, no stalls: 18-cycle start-to-done
    for (int i = 0; i < 16; i++) begin flags[i] = 1; rems[i] = 3'd0; end
    run_mb(0, 100, 0, 0, 1, 0);
    // Same with a stray start mid-parse
    run_mb(0, 100, 0, 1, 1, 0);
    // All flags clear, rem 5, chroma 3: 69 bits
    for (int i = 0; i < 16; i++) begin flags[i] = 0; rems[i] = 3'd5; end
    run_mb(3, 100, 0, 0, 0, 0);
    // Two-cycle stall in REM at block 7
    for (int i = 0; i < 16; i++) rems[i] = 3'($urandom_range(7));
    run_mb(1, 100, 1, 0, 0, 0);
    // Legal chroma 2, then illegal 00110 keeps mode 2
    run_mb(2, 100, 0, 0, 0, 0);
    run_mb(4, 100, 0, 0, 0, 0);
    // Reset in REM at block 9, then a fresh MB from block 0
    run_mb(0, 100, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) flags[i] = 1'($urandom_range(1));
    run_mb(1, 100, 0, 0, 0, 0);
    // Randomised macroblocks with random bs_valid gaps
    for (int t = 0; t < 40; t++) begin
      int csel;
      for (int i = 0; i < 16; i++) begin
        flags[i] = 1'($urandom_range(1));
        rems[i]  = 3'($urandom_range(7));
      end
      csel = ($urandom_range(9) < 8) ? int'($urandom_range(3)) : 4 + int'($urandom_range(3));
      run_mb(csel, 70, 0, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
